// File: rtl/linked_list_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : linked_list_fifo_reader
// Purpose  : Round-robin drain engine for linked_list_fifo. Pops queues into a
//            4-entry buffer and streams them out tagged with the source queue.
// Option   : LLF_READER_BURST_EN - stay on a queue for up to MAX_BURST pops.
// Revision : 1.0 - initial release
// ============================================================================
module linked_list_fifo_reader #(
    parameter int WIDTH      = 8,
    parameter int FIFOS      = 8,
    parameter int LOG2_FIFOS = 3,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  pop,
    output logic [LOG2_FIFOS-1:0] pop_fifo,
    input  logic                  fifo_empty,
    input  logic [WIDTH-1:0]      fifo_q,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WIDTH-1:0]      m_data,
    output logic [LOG2_FIFOS-1:0] m_fifo
);

    localparam logic [LOG2_FIFOS-1:0] c_last_fifo = LOG2_FIFOS'(FIFOS - 1);
    localparam logic [LOG2_FIFOS-1:0] c_fifo_one  = LOG2_FIFOS'(1);
    localparam int                    c_entry_w   = WIDTH + LOG2_FIFOS;

    if (FIFOS < 1 || LOG2_FIFOS < 1 || FIFOS > (1 << LOG2_FIFOS) || MAX_BURST < 1) begin : g_param_check
        $error("linked_list_fifo_reader: illegal parameter combination");
    end

    logic [LOG2_FIFOS-1:0] r_cur;
    logic                  r_inflight;
    logic [LOG2_FIFOS-1:0] r_tag;
    logic [c_entry_w-1:0]  r_mem [4];
    logic [1:0]            r_head;
    logic [1:0]            r_tail;
    logic [2:0]            r_occ;

    logic                  w_credit;
    logic                  w_probe;
    logic                  w_pop;
    logic                  w_advance;
    logic                  w_deq;
    logic [LOG2_FIFOS-1:0] w_cur_next;
    logic [c_entry_w-1:0]  w_head_entry;

    // Credit counts the in-flight word so a full buffer can never be overrun.
    assign w_credit   = (r_occ + {2'b00, r_inflight}) < 3'd4;
    assign w_probe    = en & w_credit;
    assign w_pop      = w_probe & ~fifo_empty & ~rst;
    assign w_deq      = (r_occ != 3'd0) & m_ready;
    assign w_cur_next = (r_cur == c_last_fifo) ? '0 : r_cur + c_fifo_one;

`ifdef LLF_READER_BURST_EN
    localparam int                   c_burst_w    = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST);
    localparam logic [c_burst_w-1:0] c_burst_last = c_burst_w'(MAX_BURST - 1);
    localparam logic [c_burst_w-1:0] c_burst_one  = c_burst_w'(1);

    logic [c_burst_w-1:0] r_burst;

    // Move on after an empty/idle probe or once this pop completes the burst.
    assign w_advance = w_probe & (~w_pop | (r_burst == c_burst_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_burst <= '0;
        end else if (w_advance) begin
            r_burst <= '0;
        end else if (w_pop) begin
            r_burst <= r_burst + c_burst_one;
        end
    end
`else
    assign w_advance = w_probe;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur <= '0;
        end else if (w_advance) begin
            r_cur <= w_cur_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_tag      <= '0;
        end else begin
            r_inflight <= w_pop;
            if (w_pop) begin
                r_tag <= r_cur;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= 2'd0;
            r_tail <= 2'd0;
            r_occ  <= 3'd0;
        end else begin
            if (r_inflight) begin
                r_tail <= r_tail + 2'd1;
            end
            if (w_deq) begin
                r_head <= r_head + 2'd1;
            end
            case ({r_inflight, w_deq})
                2'b10:   r_occ <= r_occ + 3'd1;
                2'b01:   r_occ <= r_occ - 3'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // fifo_q is only meaningful the cycle after a pop, when r_inflight is set.
    always_ff @(posedge clk) begin
        if (r_inflight && !rst) begin
            r_mem[r_tail] <= {fifo_q, r_tag};
        end
    end

    assign w_head_entry = r_mem[r_head];
    assign pop          = w_pop;
    assign pop_fifo     = r_cur;
    assign m_valid      = (r_occ != 3'd0);
    assign m_data       = m_valid ? w_head_entry[c_entry_w-1:LOG2_FIFOS] : '0;
    assign m_fifo       = m_valid ? w_head_entry[LOG2_FIFOS-1:0] : '0;

endmodule
`default_nettype wire

// File: tb/tb_linked_list_fifo_reader.sv
`default_nettype none
// Bench for linked_list_fifo_reader: emulates the multi-queue store and checks
// every delivered word against per-queue push order plus directed scenarios.
module tb_linked_list_fifo_reader;

    localparam int WIDTH      = 8;
    localparam int FIFOS      = 8;
    localparam int LOG2_FIFOS = 3;
    localparam int MAX_BURST  = 4;
    localparam int DEPTH      = 256;

    logic                  clk     = 1'b0;
    logic                  rst     = 1'b1;
    logic                  en      = 1'b0;
    logic                  m_ready = 1'b0;
    logic                  pop;
    logic                  fifo_empty;
    logic                  m_valid;
    logic [LOG2_FIFOS-1:0] pop_fifo;
    logic [LOG2_FIFOS-1:0] m_fifo;
    logic [WIDTH-1:0]      fifo_q;
    logic [WIDTH-1:0]      m_data;

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0]            store [FIFOS][DEPTH];
    int                          wr_ptr [FIFOS];
    int                          rd_ptr [FIFOS];
    int                          exp_ptr [FIFOS];
    logic [LOG2_FIFOS+WIDTH-1:0] out_log [$];
    int                          log_rd      = 0;
    int                          pending     = 0;
    int                          viol_empty  = 0;
    int                          viol_credit = 0;

    always #5 clk = ~clk;

    linked_list_fifo_reader #(
        .WIDTH      (WIDTH),
        .FIFOS      (FIFOS),
        .LOG2_FIFOS (LOG2_FIFOS),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pop        (pop),
        .pop_fifo   (pop_fifo),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_fifo     (m_fifo)
    );

    // Attached store: per-queue arrays, empty flag combinational, q registered.
    assign fifo_empty = (wr_ptr[pop_fifo] <= rd_ptr[pop_fifo]);

    always @(posedge clk) begin
        if (pop) begin
            fifo_q <= store[pop_fifo][rd_ptr[pop_fifo] % DEPTH];
            rd_ptr[pop_fifo] <= rd_ptr[pop_fifo] + 1;
        end
    end

    // Words popped but not yet delivered may never exceed the 4-word buffer.
    always @(negedge clk) begin
        if (rst) begin
            pending = 0;
        end else begin
            if (pop) begin
                if (fifo_empty) viol_empty = viol_empty + 1;
                if (pending >= 4) viol_credit = viol_credit + 1;
                pending = pending + 1;
            end
            if (m_valid && m_ready) begin
                out_log.push_back({m_fifo, m_data});
                pending = pending - 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t (limit 500000)", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic push(input int q, input logic [WIDTH-1:0] d);
        store[q][wr_ptr[q] % DEPTH] = d;
        wr_ptr[q] = wr_ptr[q] + 1;
    endtask

    function automatic int outstanding();
        int n = 0;
        for (int q = 0; q < FIFOS; q++) n += wr_ptr[q] - exp_ptr[q];
        return n - (out_log.size() - log_rd);
    endfunction

    task automatic resync();
        for (int q = 0; q < FIFOS; q++) exp_ptr[q] = rd_ptr[q];
        log_rd = out_log.size();
    endtask

    task automatic check_outputs(input string name);
        logic [LOG2_FIFOS+WIDTH-1:0] e;
        int                          q;
        while (log_rd < out_log.size()) begin
            e = out_log[log_rd];
            log_rd++;
            q = int'(e[LOG2_FIFOS+WIDTH-1:WIDTH]);
            vectors++;
            if (exp_ptr[q] >= wr_ptr[q]) begin
                miscompares++;
                $display("FAIL %s word: got data %h from queue %0d, required nothing (queue drained)",
                         name, e[WIDTH-1:0], q);
            end else begin
                if (e[WIDTH-1:0] !== store[q][exp_ptr[q] % DEPTH]) begin
                    miscompares++;
                    $display("FAIL %s word: queue %0d got %h, required %h",
                             name, q, e[WIDTH-1:0], store[q][exp_ptr[q] % DEPTH]);
                end
                exp_ptr[q]++;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        en      = 1'b1;
        m_ready = 1'b1;
        while (outstanding() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (outstanding() != 0) begin
            miscompares++;
            $display("FAIL %s drain: %0d words outstanding, required 0", name, outstanding());
        end
        check_outputs(name);
        vectors++;
        if (viol_empty != 0 || viol_credit != 0) begin
            miscompares++;
            $display("FAIL %s protocol: empty pops %0d, over-credit pops %0d, required 0 and 0",
                     name, viol_empty, viol_credit);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        en      = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        resync();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (pop !== 1'b0 || m_valid !== 1'b0 || pop_fifo !== '0 || m_data !== '0 || m_fifo !== '0) begin
            miscompares++;
            $display("FAIL reset outputs: pop %b m_valid %b pop_fifo %0d m_data %h m_fifo %0d, required all 0",
                     pop, m_valid, pop_fifo, m_data, m_fifo);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < FIFOS; i++) begin
            @(negedge clk);
            vectors++;
            if (pop_fifo !== LOG2_FIFOS'(i) || pop !== 1'b0) begin
                miscompares++;
                $display("FAIL reset scan: cycle %0d pop_fifo %0d pop %b, required %0d and 0",
                         i, pop_fifo, pop, i);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_word();
        int n = 0;
        do_reset();
        push(5, 8'hA5);
        en      = 1'b1;
        m_ready = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!pop && n < 20);
        vectors++;
        if (pop !== 1'b1 || pop_fifo !== 3'd5) begin
            miscompares++;
            $display("FAIL single pop: pop %b pop_fifo %0d, required 1 and 5", pop, pop_fifo);
        end
        @(negedge clk);
        vectors++;
        if (m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single latency: m_valid %b during capture, required 0", m_valid);
        end
        @(negedge clk);
        vectors++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5 || m_fifo !== 3'd5) begin
            miscompares++;
            $display("FAIL single word: m_valid %b m_data %h m_fifo %0d, required 1 a5 5",
                     m_valid, m_data, m_fifo);
        end
        wait_drain("single");
    endtask

    task automatic test_order();
        logic [LOG2_FIFOS+WIDTH-1:0] exp_seq [3];
        int                          first;
        do_reset();
        push(2, 8'h01);
        push(2, 8'h02);
        push(6, 8'h10);
`ifdef LLF_READER_BURST_EN
        exp_seq = '{{3'd2, 8'h01}, {3'd2, 8'h02}, {3'd6, 8'h10}};
`else
        exp_seq = '{{3'd2, 8'h01}, {3'd6, 8'h10}, {3'd2, 8'h02}};
`endif
        first = out_log.size();
        wait_drain("order");
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_log.size() <= first + i) begin
                miscompares++;
                $display("FAIL order slot %0d: no word, required queue %0d data %h",
                         i, exp_seq[i][10:8], exp_seq[i][7:0]);
            end else if (out_log[first+i] !== exp_seq[i]) begin
                miscompares++;
                $display("FAIL order slot %0d: queue %0d data %h, required queue %0d data %h",
                         i, out_log[first+i][10:8], out_log[first+i][7:0], exp_seq[i][10:8], exp_seq[i][7:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        int               pops = 0;
        int               held_bad = 0;
        bit               have = 1'b0;
        logic [WIDTH-1:0] first_word = '0;
        do_reset();
        for (int i = 0; i < 6; i++) push(0, WIDTH'($urandom));
        en = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (pop) pops++;
            if (m_valid) begin
                if (!have) begin
                    first_word = m_data;
                    have       = 1'b1;
                end else if (m_data !== first_word || m_fifo !== 3'd0) begin
                    held_bad++;
                end
            end
        end
        vectors++;
        if (pops != 4) begin
            miscompares++;
            $display("FAIL backpressure pops: %0d pops, required 4", pops);
        end
        vectors++;
        if (held_bad != 0 || m_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure hold: %0d changes, m_valid %b, required 0 and 1", held_bad, m_valid);
        end
        vectors++;
        if (first_word !== store[0][exp_ptr[0] % DEPTH]) begin
            miscompares++;
            $display("FAIL backpressure head: m_data %h, required %h", first_word, store[0][exp_ptr[0] % DEPTH]);
        end
        @(posedge clk);
        #1;
        wait_drain("backpressure");
    endtask

    task automatic test_midrun_reset();
        int pops = 0;
        int n = 0;
        int stray = 0;
        do_reset();
        for (int i = 0; i < 5; i++) push(0, WIDTH'($urandom));
        en = 1'b1;
        while (pops < 4 && n < 80) begin
            @(negedge clk);
            if (pop) pops++;
            n++;
        end
        vectors++;
        if (pops != 4) begin
            miscompares++;
            $display("FAIL midrst fill: %0d pops before reset, required 4", pops);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (pop !== 1'b0 || m_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst pre: pop %b m_valid %b, required 0 and 1", pop, m_valid);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if (m_valid !== 1'b0 || pop_fifo !== '0 || m_data !== '0 || pop !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst state: m_valid %b pop_fifo %0d m_data %h pop %b, required 0 0 00 0",
                     m_valid, pop_fifo, m_data, pop);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (m_valid !== 1'b0) stray++;
        end
        vectors++;
        if (stray != 0) begin
            miscompares++;
            $display("FAIL midrst capture: m_valid high %0d cycles after reset, required 0", stray);
        end
        resync();
        wait_drain("midrst");
    endtask

    task automatic test_back_to_back();
        int idle = 0;
`ifdef LLF_READER_BURST_EN
        int per_q = MAX_BURST;
`else
        int per_q = 3;
`endif
        do_reset();
        for (int q = 0; q < FIFOS; q++)
            for (int i = 0; i < per_q; i++) push(q, WIDTH'($urandom));
        en      = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (pop !== 1'b1) idle++;
        end
        vectors++;
        if (idle != 0) begin
            miscompares++;
            $display("FAIL back_to_back: %0d idle cycles in 20, required 0", idle);
        end
        wait_drain("back_to_back");
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            en      = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 2) == 0) push(int'($urandom_range(0, FIFOS - 1)), WIDTH'($urandom));
            @(posedge clk);
            #1;
        end
        wait_drain("random");
    endtask

`ifdef LLF_READER_BURST_EN
    task automatic test_burst();
        int                    exp_c [6] = '{3, 4, 5, 6, 14, 15};
        int                    pc [8];
        logic [LOG2_FIFOS-1:0] pf [8];
        int                    np = 0;
        do_reset();
        for (int i = 0; i < 6; i++) push(3, WIDTH'($urandom));
        en      = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (pop) begin
                if (np < 8) begin
                    pc[np] = c;
                    pf[np] = pop_fifo;
                end
                np++;
            end
        end
        vectors++;
        if (np != 6) begin
            miscompares++;
            $display("FAIL burst count: %0d pops, required 6", np);
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (i >= np || pc[i] != exp_c[i] || pf[i] !== 3'd3) begin
                miscompares++;
                $display("FAIL burst pop %0d: cycle %0d queue %0d, required cycle %0d queue 3",
                         i, (i < np) ? pc[i] : -1, (i < np) ? pf[i] : 3'd0, exp_c[i]);
            end
        end
        wait_drain("burst");
    endtask
`endif

    initial begin
        for (int q = 0; q < FIFOS; q++) begin
            wr_ptr[q]  = 0;
            exp_ptr[q] = 0;
        end
        test_reset();
        test_single_word();
        test_order();
        test_backpressure();
        test_midrun_reset();
        test_back_to_back();
`ifdef LLF_READER_BURST_EN
        test_burst();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
